div_arb_seq: RTL and testbench
==============================

DIV_ARB_SEQ -- requirements
Module: div_arb_seq

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, which selects the port that wins the first two-way tie after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports req0/req1  input  1 each  division request, port 0 / port 1.
REQ-005 SHALL have ports a0/a1  input  64 each  signed two's-complement dividend, port 0 / port 1.
REQ-006 SHALL have ports b0/b1  input  32 each  signed two's-complement divisor, port 0 / port 1.
REQ-007 SHALL have ports ack0/ack1  output  1 each  one-cycle pulse: operands of that port captured.
REQ-008 SHALL have port busy  output  1  high from grant until the done cycle inclusive.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-010 SHALL have port done_id  output  1  port that owns the current result.
REQ-011 SHALL have ports q, r  output  32 each  signed quotient and signed remainder.
REQ-012 SHALL have ports dz, dov  output  1 each  divide-by-zero flag and quotient-overflow flag.

Function
REQ-013 SHALL use a 5-state FSM: IDLE, LOAD, RUN, FIX, DONE.
REQ-014 IDLE: on an edge with req0|req1 high, SHALL capture the granted port's a/b, set busy, and go to LOAD; otherwise SHALL stay in IDLE.
REQ-015 Arbitration: single request wins; on a tie, the port not granted last wins; after reset the tie winner is RR_INIT.
REQ-016 ackN SHALL pulse high for exactly the LOAD cycle of a port-N grant; requester holds req and operands until ack and may then drop or change them.
REQ-017 A request dropped before grant SHALL be forgotten; requests during busy SHALL be ignored until IDLE.
REQ-018 LOAD: SHALL record sa=a[63] and sb=b[31], form the 64-bit |a| and 33-bit |b| (handles -2^63 and -2^31 exactly), and clear the 97-bit work register upper field.
REQ-019 LOAD: if b==0, SHALL go directly to DONE with q=0, r=0, dz=1, dov=0; otherwise SHALL go to RUN with the iteration counter set to 0.
REQ-020 RUN: each cycle SHALL shift the work register left by 1; if the upper 33 bits >= |b|, SHALL subtract |b| and set bit 0; exactly 64 RUN cycles, then FIX.
REQ-021 FIX: SHALL negate the quotient if sa^sb and negate the remainder if sa (remainder sign follows dividend); q = low 32 bits of the signed quotient.
REQ-022 FIX: dov=1 iff the magnitude quotient exceeds 2^31-1 (positive result) or 2^31 (negative result); dz=0.
REQ-023 DONE: SHALL assert done for one cycle with done_id = granted port, deassert busy after that cycle, and return to IDLE.
REQ-024 Latency: done SHALL be high 67 cycles after the grant edge for b!=0 and 2 cycles after it for b==0; a new grant is possible on the first edge after DONE.
REQ-025 q, r, dz, dov, done_id SHALL be registered, updated only when entering DONE, and held stable until the next DONE.

Reset
REQ-026 On rst_n low, SHALL asynchronously force state IDLE; busy, done, ack0, ack1, q, r, dz, dov, and done_id to 0; and the arbitration pointer to RR_INIT.
REQ-027 Reset mid-operation SHALL abort the division with no done pulse; the first grant after release SHALL behave exactly as after power-up.

Verification
REQ-028 Port 0: a=100, b=7 -> ack0 in the LOAD cycle; done 67 cycles after grant; q=14, r=2, dz=0, dov=0, done_id=0.
REQ-029 Port 1: a=-100, b=7 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2), done_id=1; a=-2^31 (sign-extended), b=-1 -> q=0x80000000, dov=1.
REQ-030 b=0 with any a -> done 2 cycles after grant; dz=1, q=0, r=0, dov=0.
REQ-031 a=0x0000_0001_0000_0000, b=1 -> dov=1, q=0x00000000, r=0; a=-2^31 (sign-extended), b=1 -> dov=0, q=0x80000000.
REQ-032 With RR_INIT=0, req0 and req1 asserted together and held -> grant order 0,1,0,1; ack pulses alternate; no request is starved.
REQ-033 rst_n low during RUN iteration 30 -> all outputs 0 immediately and no done; after release, 100/7 completes correctly.

Source files
------------

// File: rtl/div_arb_seq.sv
// Two-port arbitrated 64/32 signed divider, one restoring step per cycle.
// Results are registered and held until the next completion.
module div_arb_seq #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] a0,
    input  logic [63:0] a1,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        dz,
    output logic        dov
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic        gid, prio, gport;
    logic [63:0] a_reg;
    logic [31:0] b_reg;
    logic        sa, sb;
    logic [32:0] bmag;
    logic [96:0] work, work_nxt, sh;
    logic [5:0]  cnt;

    logic [63:0] amag_c;
    logic [32:0] bext, bmag_c;
    logic [63:0] qmag;
    logic        neg, ov;
    logic [31:0] q_c, r_c;

    assign ack0 = (state == LOAD) && !gid;
    assign ack1 = (state == LOAD) && gid;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // On a tie the pointer names the port that was not granted last.
    assign gport = (req0 && req1) ? prio : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req0 || req1) state_nxt = LOAD;
            LOAD: state_nxt = (b_reg == 32'd0) ? DONE : RUN;
            RUN:  if (cnt == 6'd63) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        amag_c = a_reg[63] ? (~a_reg + 64'd1) : a_reg;
        bext   = {b_reg[31], b_reg};
        bmag_c = b_reg[31] ? (~bext + 33'd1) : bext;
        sh       = {work[95:0], 1'b0};
        work_nxt = sh;
        if (sh[96:64] >= bmag)
            work_nxt = {sh[96:64] - bmag, sh[63:1], 1'b1};
        qmag = work[63:0];
        neg  = sa ^ sb;
        q_c  = neg ? (~qmag[31:0] + 32'd1) : qmag[31:0];
        r_c  = sa ? (~work[95:64] + 32'd1) : work[95:64];
        ov   = neg ? (qmag > 64'h0000_0000_8000_0000)
                   : (qmag > 64'h0000_0000_7FFF_FFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gid     <= 1'b0;
            prio    <= RR_INIT;
            a_reg   <= '0;
            b_reg   <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            bmag    <= '0;
            work    <= '0;
            cnt     <= '0;
            q       <= '0;
            r       <= '0;
            dz      <= 1'b0;
            dov     <= 1'b0;
            done_id <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gid   <= gport;
                        prio  <= ~gport;
                        a_reg <= gport ? a1 : a0;
                        b_reg <= gport ? b1 : b0;
                    end
                end
                LOAD: begin
                    sa   <= a_reg[63];
                    sb   <= b_reg[31];
                    bmag <= bmag_c;
                    work <= {33'd0, amag_c};
                    cnt  <= '0;
                    if (b_reg == 32'd0) begin
                        q       <= '0;
                        r       <= '0;
                        dz      <= 1'b1;
                        dov     <= 1'b0;
                        done_id <= gid;
                    end
                end
                RUN: begin
                    work <= work_nxt;
                    cnt  <= cnt + 6'd1;
                end
                FIX: begin
                    q       <= q_c;
                    r       <= r_c;
                    dz      <= 1'b0;
                    dov     <= ov;
                    done_id <= gid;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arb_seq.sv
// Directed bench for div_arb_seq: arithmetic, latency, arbitration, reset.
module tb_div_arb_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [63:0] a0 = '0, a1 = '0;
    logic [31:0] b0 = '0, b1 = '0;
    logic        ack0, ack1, busy, done, done_id, dz, dov;
    logic [31:0] q, r;

    int checks = 0;
    int failures = 0;

    div_arb_seq #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .busy(busy), .done(done), .done_id(done_id),
        .q(q), .r(r), .dz(dz), .dov(dov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input string tag, output logic [1:0] who);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack0 || ack1) && n < 20);
        who = {ack1, ack0};
        if (!(ack0 || ack1)) chk({tag, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, output int cnt);
        cnt = 0;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!done) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic do_div(input string tag, input bit p,
                          input logic [63:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input bit edz, input bit edov, input int elat);
        logic [1:0] who;
        int cnt;
        @(negedge clk);
        if (p) begin req1 = 1; a1 = a; b1 = b; end
        else   begin req0 = 1; a0 = a; b0 = b; end
        wait_ack(tag, who);
        chk({tag, "_ack"}, who, p ? 2'b10 : 2'b01);
        chk({tag, "_busy"}, busy, 1);
        req0 = 0; req1 = 0;
        a0 = 64'hDEAD_BEEF_DEAD_BEEF; a1 = ~a0;
        b0 = 32'h5A5A_5A5A; b1 = 32'hA5A5_A5A5;
        wait_done(tag, cnt);
        chk({tag, "_lat"}, cnt + 1, elat);
        chk({tag, "_id"}, done_id, p);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_r"}, r, er);
        chk({tag, "_dz"}, dz, edz);
        chk({tag, "_dov"}, dov, edov);
        chk({tag, "_busy_done"}, busy, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold_q"}, q, eq);
    endtask

    task automatic tie_run(input string tag, input int n,
                           input logic [1:0] first);
        logic [1:0] who, exp;
        int cnt;
        exp = first;
        @(negedge clk);
        req0 = 1; req1 = 1;
        a0 = 64'd5; a1 = 64'd9; b0 = '0; b1 = '0;
        for (int i = 0; i < n; i++) begin
            wait_ack(tag, who);
            chk($sformatf("%s_grant%0d", tag, i), who, exp);
            wait_done(tag, cnt);
            chk($sformatf("%s_lat%0d", tag, i), cnt + 1, 2);
            exp = ~exp;
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] who;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack", {ack1, ack0}, 0);
        chk("rst_q", q, 0);
        chk("rst_flags", {dz, dov, done_id}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;

        tie_run("rr", 4, 2'b01);

        do_div("p0_100_7", 0, 64'd100, 32'd7, 32'd14, 32'd2, 0, 0, 67);
        do_div("p1_m100_7", 1, -64'sd100, 32'd7,
               32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0, 67);
        do_div("p1_min_m1", 1, 64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 32'd0, 0, 1, 67);
        do_div("p0_bz", 0, 64'h1234_5678_9ABC_DEF0, 32'd0,
               32'd0, 32'd0, 1, 0, 2);
        do_div("p1_2p32", 1, 64'h0000_0001_0000_0000, 32'd1,
               32'd0, 32'd0, 0, 1, 67);
        do_div("p0_min_1", 0, 64'hFFFF_FFFF_8000_0000, 32'd1,
               32'h8000_0000, 32'd0, 0, 0, 67);
        do_div("p0_7_m2", 0, 64'd7, 32'hFFFF_FFFE,
               32'hFFFF_FFFD, 32'd1, 0, 0, 67);
        do_div("p1_a63_bmin", 1, 64'h8000_0000_0000_0000, 32'h8000_0000,
               32'h0000_0000, 32'd0, 0, 1, 67);

        // Abort a division part way through the iterations.
        @(negedge clk);
        req0 = 1; a0 = 64'd100; b0 = 32'd7;
        wait_ack("rst_mid", who);
        req0 = 0;
        repeat (31) @(negedge clk);
        chk("rst_mid_busy_pre", busy, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_q", q, 0);
        chk("rst_mid_r", r, 0);
        chk("rst_mid_flags", {done, dz, dov, done_id, ack0, ack1}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        begin
            bit seen = 0;
            repeat (70) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            chk("rst_mid_nodone", seen, 0);
        end
        tie_run("rr_after_rst", 1, 2'b01);
        do_div("post_rst", 0, 64'd100, 32'd7, 32'd14, 32'd2, 0, 0, 67);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
